// File: rtl/gold_nic_pkg.sv
// Shared constants for the gold_nic processor/mesh bridge: register map, data width
// and the position of the virtual-channel bit inside a flit.
package gold_nic_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 2;
  localparam int unsigned VC_BIT     = 0;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_flit_buf.sv
// One-entry flit buffer with a full flag. A load is taken only while empty; clear
// drops the flag but keeps the data, so a later read of an empty buffer sees the old flit.
module nic_flit_buf #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [0:Width-1] data_i,
  input  logic             clr_i,
  output logic [0:Width-1] data_o,
  output logic             full_o
);

  logic [0:Width-1] data_d, data_q;
  logic             full_d, full_q;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (load_i && !full_q) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/gold_nic.sv
// Memory-mapped NIC for a gold_cmp node: the processor reads/writes one receive and one
// send buffer plus status words; the buffers hand flits to and from the mesh router.
module gold_nic #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:ADDR_WIDTH-1] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);
  import gold_nic_pkg::*;

  logic                  rd, wr;
  logic                  in_load, in_clr, in_full;
  logic                  out_load, out_full;
  logic [0:DATA_WIDTH-1] in_data, out_data;

  assign rd = nicEn && !nicWrEn;
  assign wr = nicEn && nicWrEn;

  assign net_ri  = !in_full;
  assign in_load = net_si && !in_full;
  assign in_clr  = rd && (addr == NIC_IN_BUF) && in_full;

  // out_full is the pre-edge value, so a write in the send-completion cycle is dropped.
  assign out_load = wr && (addr == NIC_OUT_BUF) && !out_full;
  assign net_so   = out_full && net_ro && (out_data[VC_BIT] == net_polarity);
  assign net_do   = out_data;

  nic_flit_buf #(
    .Width (DATA_WIDTH)
  ) u_in_buf (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (in_load),
    .data_i (net_di),
    .clr_i  (in_clr),
    .data_o (in_data),
    .full_o (in_full)
  );

  nic_flit_buf #(
    .Width (DATA_WIDTH)
  ) u_out_buf (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (out_load),
    .data_i (d_in),
    .clr_i  (net_so),
    .data_o (out_data),
    .full_o (out_full)
  );

  always_comb begin
    d_out = '0;
    if (rd) begin
      case (addr)
        NIC_IN_BUF:   d_out = in_data;
        NIC_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
        NIC_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
        default:      d_out = '0;
      endcase
    end
  end

endmodule
